// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one single-port SRAM between fetch and data ports
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_if_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_mem_o,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;

    logic in_if, in_mem, done;

    assign in_if  = (state_q == IF_ACC);
    assign in_mem = (state_q == MEM_ACC);
    assign done   = (in_if || in_mem) && (cnt_q == 4'd0);

    // Data port wins ties; the fetch is picked up on the next IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    state_d = MEM_ACC;
                    cnt_d   = CNT_LOAD;
                    addr_d  = mem_addr_i;
                    data_d  = mem_data_i;
                    we_d    = mem_we_i;
                end else if (if_ce_i) begin
                    state_d = IF_ACC;
                    cnt_d   = CNT_LOAD;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                end
            end
            IF_ACC, MEM_ACC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // Every output is forced low while reset is held, even before the state has been cleared.
    assign stallreq_if_o  = !rst && if_ce_i  && !(in_if  && done);
    assign stallreq_mem_o = !rst && mem_ce_i && !(in_mem && done);
    assign if_data_o      = (!rst && in_if && done) ? sram_data_i : 32'd0;
    assign mem_data_o     = (!rst && in_mem && done && !we_q) ? sram_data_i : 32'd0;
    assign sram_ce_o      = !rst && (in_if || in_mem);
    assign sram_we_o      = !rst && in_mem && we_q;
    assign sram_addr_o    = (!rst && (in_if || in_mem)) ? addr_q : 32'd0;
    assign sram_data_o    = (!rst && in_mem) ? data_q : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - cycle-table and latency checks for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        if_ce;
        logic [31:0] if_addr;
        logic        mem_ce;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [31:0] sdi;
        logic        x_sif;
        logic        x_smem;
        logic        x_ce;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_sdo;
        logic [31:0] x_ifd;
        logic [31:0] x_memd;
    } vec_t;

    // W=1 unit driven by the table
    logic        rst, if_ce, mem_ce, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, sdi;
    logic [31:0] if_data, mem_rdata, s_addr, s_wdata;
    logic        s_if, s_mem, s_ce, s_we;

    mem_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .stallreq_if_o(s_if),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_wdata),
        .mem_data_o(mem_rdata), .stallreq_mem_o(s_mem),
        .sram_ce_o(s_ce), .sram_we_o(s_we), .sram_addr_o(s_addr), .sram_data_o(s_wdata),
        .sram_data_i(sdi)
    );

    // W=0 and W=3 units sharing one stimulus set
    logic        h_rst, h_ifce;
    logic [31:0] h_ifaddr, h_sdi;
    logic [31:0] o0_ifd, o0_memd, o0_addr, o0_sdo, o3_ifd, o3_memd, o3_addr, o3_sdo;
    logic        o0_sif, o0_smem, o0_ce, o0_we, o3_sif, o3_smem, o3_ce, o3_we;

    mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(h_rst),
        .if_ce_i(h_ifce), .if_addr_i(h_ifaddr), .if_data_o(o0_ifd), .stallreq_if_o(o0_sif),
        .mem_ce_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'd0), .mem_data_i(32'd0),
        .mem_data_o(o0_memd), .stallreq_mem_o(o0_smem),
        .sram_ce_o(o0_ce), .sram_we_o(o0_we), .sram_addr_o(o0_addr), .sram_data_o(o0_sdo),
        .sram_data_i(h_sdi)
    );

    mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(h_rst),
        .if_ce_i(h_ifce), .if_addr_i(h_ifaddr), .if_data_o(o3_ifd), .stallreq_if_o(o3_sif),
        .mem_ce_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'd0), .mem_data_i(32'd0),
        .mem_data_o(o3_memd), .stallreq_mem_o(o3_smem),
        .sram_ce_o(o3_ce), .sram_we_o(o3_we), .sram_addr_o(o3_addr), .sram_data_o(o3_sdo),
        .sram_data_i(h_sdi)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst_v, input logic ifce_v, input logic [31:0] ifaddr_v,
        input logic memce_v, input logic memwe_v, input logic [31:0] memaddr_v,
        input logic [31:0] memdata_v, input logic [31:0] sdi_v,
        input logic xsif, input logic xsmem, input logic xce, input logic xwe,
        input logic [31:0] xaddr, input logic [31:0] xsdo,
        input logic [31:0] xifd, input logic [31:0] xmemd);
        vec_t v;
        v.rst = rst_v;  v.if_ce = ifce_v;  v.if_addr = ifaddr_v;
        v.mem_ce = memce_v;  v.mem_we = memwe_v;  v.mem_addr = memaddr_v;
        v.mem_data = memdata_v;  v.sdi = sdi_v;
        v.x_sif = xsif;  v.x_smem = xsmem;  v.x_ce = xce;  v.x_we = xwe;
        v.x_addr = xaddr;  v.x_sdo = xsdo;  v.x_ifd = xifd;  v.x_memd = xmemd;
        return v;
    endfunction

    localparam int NV = 28;
    vec_t tbl [NV];
    vec_t sb [$];

    initial begin
        vec_t e;
        int lo0, lo3, ce0n, ce3n;
        logic [31:0] d0, d3, a3;
        logic ce0_at2, ce0_at3;

        // reset with requests held
        tbl[0]  = mk(1,1,32'h4,1,1,32'h20,32'h55,32'h1234,         0,0,0,0,0,0,0,0);
        tbl[1]  = mk(1,1,32'h4,1,1,32'h20,32'h55,32'h1234,         0,0,0,0,0,0,0,0);
        // fetch only
        tbl[2]  = mk(0,1,32'h4,0,0,0,0,32'h3C010001,               1,0,0,0,0,0,0,0);
        tbl[3]  = mk(0,1,32'h4,0,0,0,0,32'h3C010001,               1,0,1,0,32'h4,0,0,0);
        tbl[4]  = mk(0,1,32'h4,0,0,0,0,32'h3C010001,               0,0,1,0,32'h4,0,32'h3C010001,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,32'h3C010001,                   0,0,0,0,0,0,0,0);
        // simultaneous: data first, one IDLE, then fetch
        tbl[6]  = mk(0,1,32'h8,1,0,32'h100,0,32'hAAAA5555,         1,1,0,0,0,0,0,0);
        tbl[7]  = mk(0,1,32'h8,1,0,32'h100,0,32'hAAAA5555,         1,1,1,0,32'h100,0,0,0);
        tbl[8]  = mk(0,1,32'h8,1,0,32'h100,0,32'hAAAA5555,         1,0,1,0,32'h100,0,0,32'hAAAA5555);
        tbl[9]  = mk(0,1,32'h8,0,0,0,0,32'hAAAA5555,               1,0,0,0,0,0,0,0);
        tbl[10] = mk(0,1,32'h8,0,0,0,0,32'hAAAA5555,               1,0,1,0,32'h8,0,0,0);
        tbl[11] = mk(0,1,32'h8,0,0,0,0,32'hAAAA5555,               0,0,1,0,32'h8,0,32'hAAAA5555,0);
        tbl[12] = mk(0,0,0,0,0,0,0,32'hAAAA5555,                   0,0,0,0,0,0,0,0);
        // write; request inputs change mid-access
        tbl[13] = mk(0,0,0,1,1,32'h20,32'hDEADBEEF,32'h11111111,   0,1,0,0,0,0,0,0);
        tbl[14] = mk(0,0,0,1,1,32'h999,0,32'h11111111,             0,1,1,1,32'h20,32'hDEADBEEF,0,0);
        tbl[15] = mk(0,0,0,1,1,32'h999,0,32'h11111111,             0,0,1,1,32'h20,32'hDEADBEEF,0,0);
        tbl[16] = mk(0,0,0,0,0,0,0,32'h11111111,                   0,0,0,0,0,0,0,0);
        // ce dropped during write
        tbl[17] = mk(0,0,0,1,1,32'h40,32'hCAFEF00D,0,              0,1,0,0,0,0,0,0);
        tbl[18] = mk(0,0,0,0,0,0,0,0,                              0,0,1,1,32'h40,32'hCAFEF00D,0,0);
        tbl[19] = mk(0,0,0,0,0,0,0,0,                              0,0,1,1,32'h40,32'hCAFEF00D,0,0);
        tbl[20] = mk(0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0);
        // reset in first cycle of a write
        tbl[21] = mk(0,0,0,1,1,32'h60,32'h0BADF00D,0,              0,1,0,0,0,0,0,0);
        tbl[22] = mk(1,0,0,1,1,32'h60,32'h0BADF00D,0,              0,0,0,0,0,0,0,0);
        tbl[23] = mk(0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0);
        // clean read after reset
        tbl[24] = mk(0,0,0,1,0,32'h70,0,32'h5A5A5A5A,              0,1,0,0,0,0,0,0);
        tbl[25] = mk(0,0,0,1,0,32'h70,0,32'h5A5A5A5A,              0,1,1,0,32'h70,0,0,0);
        tbl[26] = mk(0,0,0,1,0,32'h70,0,32'h5A5A5A5A,              0,0,1,0,32'h70,0,0,32'h5A5A5A5A);
        tbl[27] = mk(0,0,0,0,0,0,0,32'h5A5A5A5A,                   0,0,0,0,0,0,0,0);

        rst = 1'b1; if_ce = 1'b0; if_addr = '0; mem_ce = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; sdi = '0;
        h_rst = 1'b1; h_ifce = 1'b0; h_ifaddr = '0; h_sdi = '0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;  if_ce = tbl[i].if_ce;  if_addr = tbl[i].if_addr;
            mem_ce = tbl[i].mem_ce;  mem_we = tbl[i].mem_we;  mem_addr = tbl[i].mem_addr;
            mem_wdata = tbl[i].mem_data;  sdi = tbl[i].sdi;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("row%0d stall_if", i),  32'(s_if),  32'(e.x_sif));
            chk($sformatf("row%0d stall_mem", i), 32'(s_mem), 32'(e.x_smem));
            chk($sformatf("row%0d sram_ce", i),   32'(s_ce),  32'(e.x_ce));
            chk($sformatf("row%0d sram_we", i),   32'(s_we),  32'(e.x_we));
            chk($sformatf("row%0d sram_addr", i), s_addr,     e.x_addr);
            chk($sformatf("row%0d sram_data", i), s_wdata,    e.x_sdo);
            chk($sformatf("row%0d if_data", i),   if_data,    e.x_ifd);
            chk($sformatf("row%0d mem_data", i),  mem_rdata,  e.x_memd);
            @(posedge clk); #1;
        end

        // fetch latency for W=0 and W=3, request held throughout
        h_rst = 1'b0; h_ifce = 1'b1; h_ifaddr = 32'hC; h_sdi = 32'h77;
        lo0 = -1; lo3 = -1; ce0n = 0; ce3n = 0; d0 = '0; d3 = '0; a3 = '0;
        ce0_at2 = 1'bx; ce0_at3 = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lo0 < 0) begin
                if (o0_ce) ce0n++;
                if (!o0_sif) begin lo0 = k; d0 = o0_ifd; end
            end
            if (lo3 < 0) begin
                if (o3_ce) ce3n++;
                if (!o3_sif) begin lo3 = k; d3 = o3_ifd; a3 = o3_addr; end
            end
            if (k == 2) ce0_at2 = o0_ce;
            if (k == 3) ce0_at3 = o0_ce;
            @(posedge clk); #1;
        end
        chk("w0 done_cycle",  32'(lo0), 32'd1);
        chk("w0 ce_cycles",   32'(ce0n), 32'd1);
        chk("w0 if_data",     d0, 32'h77);
        chk("w0 idle_gap_ce", 32'(ce0_at2), 32'd0);
        chk("w0 regrant_ce",  32'(ce0_at3), 32'd1);
        chk("w3 done_cycle",  32'(lo3), 32'd4);
        chk("w3 ce_cycles",   32'(ce3n), 32'd4);
        chk("w3 if_data",     d3, 32'h77);
        chk("w3 sram_addr",   a3, 32'hC);

        // reset asserted with a fetch still requested
        h_rst = 1'b1;
        @(negedge clk);
        chk("w0 rst stall_if", 32'(o0_sif), 32'd0);
        chk("w3 rst stall_if", 32'(o3_sif), 32'd0);
        chk("w3 rst sram_ce",  32'(o3_ce),  32'd0);
        chk("w3 rst sram_addr", o3_addr,    32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra SRAM wait cycles per access (legal range 0..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_ce_i  input  1  instruction-fetch request, held until served.
REQ-005 SHALL have port if_addr_i  input  32  fetch address.
REQ-006 SHALL have port if_data_o  output  32  fetched instruction.
REQ-007 SHALL have port stallreq_if_o  output  1  fetch not yet served.
REQ-008 SHALL have port mem_ce_i  input  1  data-access request, held until served.
REQ-009 SHALL have port mem_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port mem_addr_i  input  32  data address.
REQ-011 SHALL have port mem_data_i  input  32  store data.
REQ-012 SHALL have port mem_data_o  output  32  load data.
REQ-013 SHALL have port stallreq_mem_o  output  1  data access not yet served.
REQ-014 SHALL have ports sram_ce_o (output 1), sram_we_o (output 1), sram_addr_o (output 32), sram_data_o (output 32) and sram_data_i (input 32): the single shared single-port SRAM.

Function
REQ-015 SHALL implement states IDLE, IF_ACC, MEM_ACC and a 4-bit wait counter cnt.
REQ-016 In IDLE with mem_ce_i=1, SHALL latch mem_addr_i/mem_data_i/mem_we_i, load cnt=WAIT_CYCLES, go to MEM_ACC; data port has fixed priority over fetch.
REQ-017 In IDLE with mem_ce_i=0 and if_ce_i=1, SHALL latch if_addr_i, load cnt=WAIT_CYCLES, go to IF_ACC.
REQ-018 In IDLE with no request, SHALL stay in IDLE with sram_ce_o=0.
REQ-019 In IF_ACC/MEM_ACC, SHALL drive sram_ce_o=1 and sram_addr_o=latched address; sram_we_o and sram_data_o follow latched values in MEM_ACC only (sram_we_o=0 in IF_ACC).
REQ-020 In an access state with cnt>0, SHALL decrement cnt; at cnt=0 ("done"), SHALL return to IDLE next cycle.
REQ-021 Each access SHALL occupy WAIT_CYCLES+1 cycles in the access state; grant-to-done latency is WAIT_CYCLES+2 cycles including the IDLE grant cycle.
REQ-022 stallreq_if_o SHALL equal if_ce_i AND NOT (IF_ACC AND done); stallreq_mem_o SHALL equal mem_ce_i AND NOT (MEM_ACC AND done). Both are combinational.
REQ-023 In the done cycle, if_data_o (IF_ACC) or mem_data_o (MEM_ACC read) SHALL equal sram_data_i combinationally; otherwise that output SHALL be 0.
REQ-024 Latched address/data SHALL NOT change during an access even if request inputs change.
REQ-025 If a requester deasserts ce mid-access, the access SHALL still complete (a write is committed) and the result SHALL be discarded; no abort.
REQ-026 Simultaneous requests: MEM is served first; IF is granted in the IDLE cycle following MEM done, if still requested. stallreq_if_o stays high throughout.
REQ-027 The arbiter SHALL insert exactly one IDLE cycle between consecutive accesses; no back-to-back grant.
REQ-028 With WAIT_CYCLES=0, the done condition SHALL hold in the first access-state cycle.

Reset
REQ-029 While rst=1 at a clock edge: state SHALL become IDLE, cnt 0, latched address/data/we 0.
REQ-030 While rst=1, all outputs (stall, data and sram_*) SHALL be 0, regardless of inputs.
REQ-031 Reset mid-access SHALL abandon the access; sram_ce_o SHALL be 0 the cycle after the reset edge.

Verification
REQ-032 Fetch only, W=1, if_ce_i=1, if_addr_i=0x4, sram_data_i=0x3C010001: stall high in T0..T1, low in T2 with if_data_o=0x3C010001; sram_ce_o high in T1..T2 with addr 0x4.
REQ-033 Simultaneous if_ce_i=1 and mem_ce_i=1 (read, addr 0x100, W=1): MEM_ACC in T1..T2 with stallreq_mem_o low in T2; IDLE in T3; IF_ACC in T4..T5 with stallreq_if_o low in T5.
REQ-034 Write, mem_we_i=1, mem_addr_i=0x20, mem_data_i=0xDEADBEEF: sram_we_o=1, sram_addr_o=0x20, sram_data_o=0xDEADBEEF for two cycles; mem_data_o=0.
REQ-035 W=0, fetch only: IF_ACC done in T1; stall high in T0 only; IDLE in T2; sram_ce_o high in T1 only.
REQ-036 rst=1 during the T1 cycle of a MEM_ACC write: IDLE and sram_ce_o=0 from T2; no further write; all outputs 0 while rst=1.
REQ-037 mem_ce_i dropped to 0 in T1 of a write: write completes through T2; stallreq_mem_o=0 from T1.
